// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser
// ---------------------------------------------------------------------------
// Pulls bytes from an 8-bit synchronous receive FIFO and decodes framed
// register-write packets:
//   SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM
//   CSUM = (ADDR + LEN + sum(payload)) mod 256
// The payload is buffered and only replayed as back-to-back register writes
// (auto-incrementing, wrapping address) once the checksum matches. Malformed
// or stalled packets are dropped with a pkt_err pulse and counted.
//
// Handshake: fifo_rd_en is a one-cycle read strobe, only raised when
// fifo_empty is low and no read is in flight; the FIFO presents the byte on
// fifo_rd_data in the following cycle, where it is consumed. reg_wr_en is a
// fire-and-forget strobe (no back-pressure): one write per cycle it is high.
//
// Ports
//   usb_clk_60m   in   clock
//   sys_rst_n     in   asynchronous active-low reset
//   fifo_empty    in   receive FIFO empty
//   fifo_rd_en    out  FIFO read strobe
//   fifo_rd_data  in   FIFO read data (valid the cycle after fifo_rd_en)
//   reg_wr_en     out  register write strobe
//   reg_wr_addr   out  register address
//   reg_wr_data   out  register data
//   pkt_ok        out  pulse with the last write of a committed packet
//   pkt_err       out  pulse when a packet is discarded
//   err_cnt       out  discarded-packet count, saturating at 255
//   busy          out  high whenever the parser is not hunting for SYNC_BYTE
//   dbg_state     out  current FSM state (debug)
// ---------------------------------------------------------------------------
module usb_cmd_parser #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic       usb_clk_60m,
  input  logic       sys_rst_n,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [7:0] err_cnt,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_HUNT   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  logic [2:0]    state_q;
  logic [2:0]    next_state;
  logic          rd_vld_q;     // a byte requested last cycle is on fifo_rd_data
  logic [7:0]    addr_q;
  logic [7:0]    len_q;
  logic [7:0]    sum_q;
  logic [7:0]    idx_q;        // payload index in DATA, write index in COMMIT
  logic [TW-1:0] tmo_q;

  logic [7:0]    buf_mem [MAX_LEN];

  logic          in_pkt;
  logic          tmo_fire;
  logic          take;
  logic          err;
  logic          commit_go;
  logic          wr_go;
  logic [7:0]    wr_idx;
  logic [7:0]    last_idx;
  logic          rd_go;

  assign dbg_state = state_q;

  always_comb begin
    in_pkt     = (state_q == S_ADDR) || (state_q == S_LEN) ||
                 (state_q == S_DATA) || (state_q == S_CSUM);
    tmo_fire   = in_pkt && (tmo_q == TMO_LAST);
    // A byte arriving in the timeout cycle is dropped; the timeout wins.
    take       = rd_vld_q && !tmo_fire;
    last_idx   = len_q - 8'd1;
    next_state = state_q;
    err        = 1'b0;
    commit_go  = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (take && (fifo_rd_data == SYNC_BYTE)) next_state = S_ADDR;
      end
      S_ADDR: begin
        if (take) next_state = S_LEN;
      end
      S_LEN: begin
        if (take) begin
          if ((fifo_rd_data == 8'd0) || (fifo_rd_data > MAX_LEN_B)) err = 1'b1;
          else next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (take && (idx_q == last_idx)) next_state = S_CSUM;
      end
      S_CSUM: begin
        if (take) begin
          if (fifo_rd_data == sum_q) begin
            next_state = S_COMMIT;
            commit_go  = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        // idx_q is the write currently on the bus; leave after the last one.
        if (idx_q == last_idx) next_state = S_HUNT;
      end
      default: next_state = S_HUNT;
    endcase

    if (tmo_fire) err = 1'b1;
    if (err) next_state = S_HUNT;

    // The first write is launched by the CSUM edge itself, so COMMIT only
    // has to walk the remaining LEN-1 entries.
    wr_go  = commit_go || ((state_q == S_COMMIT) && (next_state == S_COMMIT));
    wr_idx = commit_go ? 8'd0 : (idx_q + 8'd1);

    // fifo_rd_en is registered: decide now for next cycle. Never request
    // while a read is already in flight, nor when heading into COMMIT.
    rd_go  = (next_state != S_COMMIT) && !fifo_empty && !fifo_rd_en;
  end

  always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_HUNT;
      rd_vld_q    <= 1'b0;
      addr_q      <= 8'd0;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      tmo_q       <= '0;
      fifo_rd_en  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= 8'd0;
      reg_wr_data <= 8'd0;
      pkt_ok      <= 1'b0;
      pkt_err     <= 1'b0;
      err_cnt     <= 8'd0;
      busy        <= 1'b0;
    end else begin
      state_q    <= next_state;
      rd_vld_q   <= fifo_rd_en;
      fifo_rd_en <= rd_go;
      busy       <= (next_state != S_HUNT);
      pkt_err    <= err;
      reg_wr_en  <= wr_go;
      pkt_ok     <= 1'b0;

      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      // Idle counter restarts on every accepted byte and outside a packet.
      if (!in_pkt || take || err) tmo_q <= '0;
      else                        tmo_q <= tmo_q + 1'b1;

      if (take) begin
        case (state_q)
          S_ADDR: begin
            addr_q <= fifo_rd_data;
            sum_q  <= fifo_rd_data;
          end
          S_LEN: begin
            if (!err) begin
              len_q <= fifo_rd_data;
              sum_q <= sum_q + fifo_rd_data;
              idx_q <= 8'd0;
            end
          end
          S_DATA: begin
            sum_q <= sum_q + fifo_rd_data;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end

      if (wr_go) begin
        idx_q       <= wr_idx;
        reg_wr_addr <= addr_q + wr_idx;
        reg_wr_data <= buf_mem[wr_idx[IW-1:0]];
        pkt_ok      <= (wr_idx == last_idx);
      end
    end
  end

  // Payload buffer: contents are irrelevant after reset, so no reset here.
  always_ff @(posedge usb_clk_60m) begin
    if (take && (state_q == S_DATA)) buf_mem[idx_q[IW-1:0]] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
module tb_usb_cmd_parser;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       pkt_ok;
  logic       pkt_err;
  logic [7:0] err_cnt;
  logic       busy;
  logic [2:0] dbg_state;

  usb_cmd_parser #(
    .MAX_LEN  (16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (1024)
  ) dut (
    .usb_clk_60m (clk),
    .sys_rst_n   (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err),
    .err_cnt     (err_cnt),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // {first_of_burst, pkt_ok, addr, data}
  logic [17:0] exp_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  v[$];
  bit          gap_mode = 1'b0;
  int          exp_errs = 0;
  int          exp_oks  = 0;
  int          seen_errs = 0;
  int          seen_oks  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model (driver side) ----------------
  initial begin : fifo_model
    bit prev_rd;
    prev_rd      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd = 1'b0;
      end else begin
        if (fifo_rd_en) begin
          check("rd_while_empty", int'(fifo_empty), 0);
          check("rd_back_to_back", int'(prev_rd), 0);
          if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        end
        prev_rd = fifo_rd_en;
      end
      if (src_q.size() > 0 && (!gap_mode || $urandom_range(0, 3) == 0))
        fifo_q.push_back(src_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [17:0] e;
    bit prev_wr;
    bit prev_ok;
    int err_model;
    prev_wr   = 1'b0;
    prev_ok   = 1'b0;
    err_model = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr   = 1'b0;
        prev_ok   = 1'b0;
        err_model = 0;
      end else begin
        if (reg_wr_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     reg_wr_addr, reg_wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", int'(reg_wr_addr), int'(e[15:8]));
            check("wr_data", int'(reg_wr_data), int'(e[7:0]));
            check("wr_pkt_ok", int'(pkt_ok), int'(e[16]));
            if (!e[17]) check("wr_consecutive", int'(prev_wr), 1);
          end
        end else begin
          if (pkt_ok) check("stray_pkt_ok", int'(pkt_ok), 0);
          if (prev_wr && !prev_ok) check("burst_broken", int'(reg_wr_en), 1);
        end
        if (pkt_ok) seen_oks++;
        if (pkt_err) begin
          seen_errs++;
          err_model = (err_model == 255) ? 255 : err_model + 1;
          check("err_cnt_at_pulse", int'(err_cnt), err_model);
        end
        prev_wr = reg_wr_en;
        prev_ok = pkt_ok;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_v();
    foreach (v[i]) src_q.push_back(v[i]);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d,
                           input bit first, input bit ok);
    exp_q.push_back({first, ok, a, d});
  endtask

  task automatic send_valid_pkt();
    expect_wr(8'h10, 8'h11, 1'b1, 1'b0);
    expect_wr(8'h11, 8'h22, 1'b0, 1'b0);
    expect_wr(8'h12, 8'h33, 1'b0, 1'b1);
    exp_oks++;
    v = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
    push_v();
  endtask

  task automatic send_wrap_pkt();
    expect_wr(8'hFE, 8'h01, 1'b1, 1'b0);
    expect_wr(8'hFF, 8'h02, 1'b0, 1'b0);
    expect_wr(8'h00, 8'h03, 1'b0, 1'b1);
    exp_oks++;
    v = '{8'h00, 8'hFF, 8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h07};
    push_v();
  endtask

  // LEN=16 at 0x20, payload 0x01..0x10: 0x20+0x10+0x88 = 0xB8
  task automatic send_len16_pkt();
    v = '{8'hA5, 8'h20, 8'h10};
    for (int i = 0; i < 16; i++) begin
      v.push_back(8'(i + 1));
      expect_wr(8'(32 + i), 8'(i + 1), i == 0, i == 15);
    end
    v.push_back(8'hB8);
    exp_oks++;
    push_v();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int  stable;
    bit  done;
    stable = 0;
    done   = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (src_q.size() == 0 && fifo_q.size() == 0 && !busy && !fifo_rd_en &&
          exp_q.size() == 0) stable++;
      else stable = 0;
      if (stable >= 4) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle: not idle after %0d cycles (pending writes %0d)",
               tag, budget, exp_q.size());
    end
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_err_cnt"}, int'(err_cnt), (exp_errs > 255) ? 255 : exp_errs);
    check({tag, "_err_pulses"}, seen_errs, exp_errs);
    check({tag, "_ok_pulses"}, seen_oks, exp_oks);
    check({tag, "_state_hunt"}, int'(dbg_state), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"}, int'({reg_wr_en, reg_wr_addr, reg_wr_data}), 0);
    check({tag, "_flags"}, int'({fifo_rd_en, pkt_ok, pkt_err, busy}), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit seen_first;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // valid packet
    send_valid_pkt();
    wait_idle(200, "valid");
    checkpoint("valid");

    // address wrap with leading garbage
    send_wrap_pkt();
    wait_idle(200, "wrap");
    checkpoint("wrap");

    // bad checksum, then a good packet
    v = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h78};
    push_v();
    exp_errs++;
    wait_idle(200, "bad_csum");
    checkpoint("bad_csum");
    send_valid_pkt();
    wait_idle(200, "after_bad");
    checkpoint("after_bad");

    // length limits
    v = '{8'hA5, 8'h10, 8'h00};
    push_v();
    exp_errs++;
    wait_idle(200, "len0");
    v = '{8'hA5, 8'h10, 8'h11};
    push_v();
    exp_errs++;
    wait_idle(200, "len17");
    checkpoint("len_limits");
    send_len16_pkt();
    wait_idle(400, "len16");
    checkpoint("len16");

    // timeout inside a packet
    v = '{8'hA5, 8'h10};
    push_v();
    repeat (900) @(negedge clk);
    check("no_early_timeout", seen_errs, exp_errs);
    exp_errs++;
    wait_idle(2000, "timeout");
    checkpoint("timeout");
    send_valid_pkt();
    wait_idle(200, "after_timeout");
    checkpoint("after_timeout");

    // throttled FIFO
    gap_mode = 1'b1;
    send_valid_pkt();
    send_wrap_pkt();
    send_len16_pkt();
    wait_idle(3000, "throttle");
    gap_mode = 1'b0;
    checkpoint("throttle");

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      v = '{8'hA5, 8'h10, 8'h00};
      push_v();
      exp_errs++;
    end
    wait_idle(8000, "saturate");
    checkpoint("saturate");
    check("err_cnt_saturated", int'(err_cnt), 255);

    // reset during the second write of a 3-byte packet
    expect_wr(8'h10, 8'h11, 1'b1, 1'b0);
    v = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
    push_v();
    seen_first = 1'b0;
    for (int i = 0; i < 200 && !seen_first; i++) begin
      @(negedge clk);
      if (reg_wr_en) seen_first = 1'b1;
    end
    check("first_write_before_reset", int'(seen_first), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    src_q.delete();
    fifo_q.delete();
    #1;
    check_all_zero("mid_commit_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("pending_writes_after_reset", exp_q.size(), 0);
    check_all_zero("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_cmd_parser.md
# usb_cmd_parser

Consumes the received USB byte stream from the read port of the 8-bit synchronous receive FIFO and decodes framed register-write packets. A packet carries a start address, a length, a payload and a checksum. The payload is held in an internal buffer until the checksum verifies. Only then is it replayed as back-to-back register writes, with an auto-incrementing address, to the control-register bank of the image pipeline; malformed packets produce no writes.

## Interface
Parameters:
- MAX_LEN, 16: largest accepted payload length in bytes (1..255); sets buffer depth.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT, 1024: idle cycles allowed between bytes inside a packet before abort (≥ 4).

Ports:
- usb_clk_60m  in  1  sole clock, 60 MHz.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- fifo_empty  in  1  receive FIFO empty.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  8  FIFO read data, valid the cycle after fifo_rd_en.
- reg_wr_en  out  1  register write strobe, one write per cycle.
- reg_wr_addr  out  8  register address.
- reg_wr_data  out  8  register data.
- pkt_ok  out  1  one-cycle pulse: packet committed.
- pkt_err  out  1  one-cycle pulse: packet discarded.
- err_cnt  out  8  discarded-packet count, saturating at 255.
- busy  out  1  high in every state except HUNT.

## Operation
- Frame: SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM. CSUM = (ADDR + LEN + Σpayload) mod 256.
- States and transitions:
  - HUNT: discard bytes ≠ SYNC_BYTE; SYNC_BYTE → ADDR.
  - ADDR: latch ADDR; start the running sum; → LEN.
  - LEN: LEN = 0 or LEN > MAX_LEN → error; otherwise latch LEN, add it to the sum → DATA.
  - DATA: write byte to buffer[idx] and add it to the sum; after byte LEN-1 → CSUM.
  - CSUM: match → COMMIT; mismatch → error.
  - COMMIT: emit LEN writes, then → HUNT.
- Error: pulse pkt_err, increment err_cnt (saturating), → HUNT. Payload is never written on error.
- Byte fetch, in HUNT through CSUM only:
  - fifo_rd_en = 1 for one cycle when fifo_empty = 0 and no read is outstanding.
  - fifo_rd_data is sampled the next cycle.
  - Maximum intake is 1 byte per 2 cycles.
  - fifo_rd_en is never asserted in COMMIT, or while fifo_empty = 1.
- COMMIT write k (k = 0..LEN-1): reg_wr_addr = (ADDR + k) mod 256, reg_wr_data = buffer[k]. Address wraps 0xFF→0x00.
- Timeout: a cycle counter runs in ADDR/LEN/DATA/CSUM and clears on each sampled byte. Reaching TIMEOUT → error. No timeout in HUNT or COMMIT.
- A byte sampled in the same cycle as a timeout is ignored; the timeout wins.
- A SYNC_BYTE value inside a packet is ordinary data; there is no resync.

## Timing
- Reset values: all outputs 0; state HUNT; err_cnt 0. Reset mid-packet or mid-COMMIT aborts immediately. No further writes occur; buffer contents are don't-care.
- All outputs are registered.
- Let E be the edge that samples CSUM:
  - COMMIT starts at E; first reg_wr_en is high in the cycle after E.
  - LEN writes occupy consecutive cycles.
  - pkt_ok is high in the same cycle as the last write.
  - First fifo_rd_en of the next packet comes no earlier than the cycle after the last write.
- pkt_err is high the cycle after the offending byte is sampled, or the cycle after the timeout count is reached.
- err_cnt updates in the same cycle pkt_err is high.
- busy rises the cycle after SYNC_BYTE is sampled and falls the cycle after the last write or the error pulse.

## Test plan
- Valid packet: A5 10 03 11 22 33 79 → writes (0x10,0x11), (0x11,0x22), (0x12,0x33) on 3 consecutive cycles; pkt_ok with third write; err_cnt 0.
- Wrap plus leading garbage: 00 FF A5 FE 03 01 02 03 07 → garbage ignored; writes at FE, FF, 00 with data 01, 02, 03; one pkt_ok.
- Bad checksum: A5 10 03 11 22 33 78 → no reg_wr_en, one pkt_err, err_cnt = 1. Then the valid packet from scenario 1 → 3 writes.
- Length limits: LEN = 0x00 and LEN = 0x11 (MAX_LEN 16) → pkt_err after the LEN byte, err_cnt = 2, no writes. LEN = 16 with correct checksum → 16 writes, back-to-back.
- Timeout and reset: A5 10, then FIFO empty for 1024 cycles → pkt_err, state HUNT; a later valid packet commits. Then assert sys_rst_n during the 2nd write of a 3-byte packet → no further writes; all outputs read 0.
- Throttling and saturation: random fifo_empty gaps → fifo_rd_en never high while empty, and never high on 2 consecutive cycles. 300 bad packets → err_cnt holds 255.
